// File: rtl/seg_msg_receiver_pkg.sv
// seg_msg_receiver_pkg: symbol codes, segment patterns and FSM states shared by the HELLO receiver and its decoder
package seg_msg_receiver_pkg;

    typedef enum logic [2:0] {
        SYM_BLANK = 3'd0,
        SYM_H     = 3'd1,
        SYM_E     = 3'd2,
        SYM_L     = 3'd3,
        SYM_O     = 3'd4,
        SYM_BAD   = 3'd7
    } sym_t;

    // Active-low segment patterns, bit6 = g ... bit0 = a
    localparam logic [6:0] SEG_H     = 7'h09;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_L     = 7'h47;
    localparam logic [6:0] SEG_O     = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GOT_H  = 3'd1,
        GOT_E  = 3'd2,
        GOT_L0 = 3'd3,
        GOT_L1 = 3'd4,
        DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/seg_msg_receiver_if.sv
// seg_msg_receiver_if: character input and status outputs of the HELLO receiver
//   in_valid/in_char/lock_in : character stream from the transmitter
//   sym/sym_valid/bad_char   : last decoded symbol and its pulses
//   hist                     : last four symbols, newest in [2:0]
//   match/msg_ok             : HELLO completion pulse and level
//   char_cnt/err_cnt         : saturating accepted/invalid counters
interface seg_msg_receiver_if #(parameter int CNT_W = 4);

    logic             in_valid;
    logic [6:0]       in_char;
    logic             lock_in;
    logic [2:0]       sym;
    logic             sym_valid;
    logic [11:0]      hist;
    logic             match;
    logic             msg_ok;
    logic             bad_char;
    logic [CNT_W-1:0] char_cnt;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output in_valid, in_char, lock_in,
        input  sym, sym_valid, hist, match, msg_ok, bad_char, char_cnt, err_cnt
    );

    modport slave (
        input  in_valid, in_char, lock_in,
        output sym, sym_valid, hist, match, msg_ok, bad_char, char_cnt, err_cnt
    );

endinterface

// File: rtl/seg_msg_receiver_seg_decode.sv
// seg_decode: maps an active-low 7-segment code to a 3-bit symbol
//   code_i : segment code, bit6 = g ... bit0 = a
//   sym_o  : 0 blank, 1 H, 2 E, 3 L, 4 O, 7 anything else
module seg_decode
    import seg_msg_receiver_pkg::*;
(
    input  logic [6:0] code_i,
    output logic [2:0] sym_o
);

    always_comb
        sym_o = code_i == SEG_BLANK ? SYM_BLANK :
                code_i == SEG_H     ? SYM_H     :
                code_i == SEG_E     ? SYM_E     :
                code_i == SEG_L     ? SYM_L     :
                code_i == SEG_O     ? SYM_O     : SYM_BAD;

endmodule

// File: rtl/seg_msg_receiver.sv
// seg_msg_receiver: decodes a 7-segment character stream, tracks HELLO, keeps history and counters
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : slave side of seg_msg_receiver_if (character input, registered status outputs)
module seg_msg_receiver
    import seg_msg_receiver_pkg::*;
#(
    parameter int CNT_W          = 4,
    parameter bit SEG_ACTIVE_LOW = 1
)
(
    input  logic           clk,
    input  logic           reset,
    seg_msg_receiver_if.slave bus
);

    logic             acc;
    logic [2:0]       dec_sym;
    state_t           state_q, state_d;
    logic             msg_ok_q, msg_ok_d;
    logic             match_q, match_d;
    logic             sym_valid_q, bad_q;
    logic [2:0]       sym_q;
    logic [11:0]      hist_q;
    logic [CNT_W-1:0] char_cnt_q, err_cnt_q;

    assign acc = bus.in_valid & ~bus.lock_in;

    // Decoder expects active-low segments, so active-high sources are inverted first
    seg_decode u_dec (
        .code_i (SEG_ACTIVE_LOW ? bus.in_char : ~bus.in_char),
        .sym_o  (dec_sym)
    );

    always_comb begin
        state_d  = state_q;
        msg_ok_d = msg_ok_q;
        match_d  = 1'b0;
        if (acc) begin
            // An H restarts the message from any state
            if (dec_sym == SYM_H) begin
                state_d  = GOT_H;
                msg_ok_d = state_q == DONE ? 1'b0 : msg_ok_q;
            end else begin
                case (state_q)
                    GOT_H:   state_d = dec_sym == SYM_E ? GOT_E  : IDLE;
                    GOT_E:   state_d = dec_sym == SYM_L ? GOT_L0 : IDLE;
                    GOT_L0:  state_d = dec_sym == SYM_L ? GOT_L1 : IDLE;
                    GOT_L1: begin
                        state_d  = dec_sym == SYM_O ? DONE : IDLE;
                        match_d  = dec_sym == SYM_O;
                        msg_ok_d = msg_ok_q | (dec_sym == SYM_O);
                    end
                    DONE:    state_d = dec_sym == SYM_BLANK ? DONE : IDLE;
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            msg_ok_q    <= 1'b0;
            match_q     <= 1'b0;
            sym_valid_q <= 1'b0;
            bad_q       <= 1'b0;
            sym_q       <= '0;
            hist_q      <= '0;
            char_cnt_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            msg_ok_q    <= msg_ok_d;
            match_q     <= match_d;
            sym_valid_q <= acc;
            bad_q       <= acc && dec_sym == SYM_BAD;
            if (acc) begin
                sym_q      <= dec_sym;
                hist_q     <= {hist_q[8:0], dec_sym};
                char_cnt_q <= &char_cnt_q ? char_cnt_q : char_cnt_q + CNT_W'(1);
                err_cnt_q  <= (dec_sym != SYM_BAD || &err_cnt_q) ? err_cnt_q : err_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.sym       = sym_q;
    assign bus.sym_valid = sym_valid_q;
    assign bus.hist      = hist_q;
    assign bus.match     = match_q;
    assign bus.msg_ok    = msg_ok_q;
    assign bus.bad_char  = bad_q;
    assign bus.char_cnt  = char_cnt_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_seg_msg_receiver.sv
// tb_seg_msg_receiver: scoreboard bench for seg_msg_receiver with directed HELLO streams
module tb_seg_msg_receiver;
    import seg_msg_receiver_pkg::*;

    typedef struct packed {
        logic [2:0]  sym;
        logic        bad;
        logic        match;
        logic        ok;
        logic [11:0] hist;
        logic [3:0]  cc;
        logic [3:0]  ec;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int tests = 0;
    int fails = 0;
    exp_t q[$];
    logic [11:0] m_hist = '0;
    logic [3:0]  m_cc = '0;
    logic [3:0]  m_ec = '0;

    seg_msg_receiver_if #(.CNT_W(4)) bus ();

    seg_msg_receiver #(.CNT_W(4), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: every sym_valid pops one expected response; pulses must be quiet otherwise
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.sym_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_sym_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sym", 32'(bus.sym), 32'(e.sym));
                    chk("bad_char", 32'(bus.bad_char), 32'(e.bad));
                    chk("match", 32'(bus.match), 32'(e.match));
                    chk("msg_ok", 32'(bus.msg_ok), 32'(e.ok));
                    chk("hist", 32'(bus.hist), 32'(e.hist));
                    chk("char_cnt", 32'(bus.char_cnt), 32'(e.cc));
                    chk("err_cnt", 32'(bus.err_cnt), 32'(e.ec));
                end
            end else begin
                chk("idle_pulses", {30'd0, bus.match, bus.bad_char}, 32'd0);
            end
        end
    end

    task automatic send(input logic [6:0] c, input logic [2:0] es, input logic em, input logic eok);
        exp_t e;
        bus.in_valid = 1'b1;
        bus.lock_in  = 1'b0;
        bus.in_char  = c;
        m_hist = {m_hist[8:0], es};
        if (m_cc != 4'hF) m_cc = m_cc + 4'd1;
        if (es == 3'd7 && m_ec != 4'hF) m_ec = m_ec + 4'd1;
        e = '{sym: es, bad: es == 3'd7, match: em, ok: eok, hist: m_hist, cc: m_cc, ec: m_ec};
        q.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.lock_in  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        chk("rst_sym", 32'(bus.sym), 32'd0);
        chk("rst_hist", 32'(bus.hist), 32'd0);
        chk("rst_pulses", {28'd0, bus.sym_valid, bus.match, bus.bad_char, bus.msg_ok}, 32'd0);
        chk("rst_cnts", {24'd0, bus.char_cnt, bus.err_cnt}, 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        m_hist = '0;
        m_cc = '0;
        m_ec = '0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.lock_in  = 1'b0;
        bus.in_char  = 7'h7F;
        do_reset();
        // Reset mid-message after H, E, then a clean HELLO
        send(SEG_H, 3'd1, 1'b0, 1'b0);
        send(SEG_E, 3'd2, 1'b0, 1'b0);
        idle(1);
        do_reset();
        send(SEG_H, 3'd1, 1'b0, 1'b0);
        send(SEG_E, 3'd2, 1'b0, 1'b0);
        send(SEG_L, 3'd3, 1'b0, 1'b0);
        send(SEG_L, 3'd3, 1'b0, 1'b0);
        send(SEG_O, 3'd4, 1'b1, 1'b1);
        idle(1);
        chk("hello_hist", 32'(bus.hist), 32'(12'b010_011_011_100));
        chk("hello_cnt", 32'(bus.char_cnt), 32'd5);
        chk("hello_msg_ok", 32'(bus.msg_ok), 32'd1);
        // Restart on second H; H in DONE clears msg_ok
        send(SEG_H, 3'd1, 1'b0, 1'b0);
        send(SEG_E, 3'd2, 1'b0, 1'b0);
        send(SEG_L, 3'd3, 1'b0, 1'b0);
        send(SEG_H, 3'd1, 1'b0, 1'b0);
        send(SEG_E, 3'd2, 1'b0, 1'b0);
        send(SEG_L, 3'd3, 1'b0, 1'b0);
        send(SEG_L, 3'd3, 1'b0, 1'b0);
        send(SEG_O, 3'd4, 1'b1, 1'b1);
        idle(1);
        chk("restart_err_cnt", 32'(bus.err_cnt), 32'd0);
        chk("restart_char_cnt", 32'(bus.char_cnt), 32'd13);
        // Blank in DONE holds; H leaves DONE and clears msg_ok
        send(SEG_BLANK, 3'd0, 1'b0, 1'b1);
        chk("done_blank_state", 32'(dut.state_q), 32'(DONE));
        send(SEG_H, 3'd1, 1'b0, 1'b0);
        chk("done_h_state", 32'(dut.state_q), 32'(GOT_H));
        // Lock mid-message freezes progress, then resume
        send(SEG_E, 3'd2, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        bus.lock_in  = 1'b1;
        bus.in_char  = SEG_BLANK;
        repeat (3) @(posedge clk);
        #1;
        chk("lock_state", 32'(dut.state_q), 32'(GOT_E));
        send(SEG_L, 3'd3, 1'b0, 1'b0);
        send(SEG_L, 3'd3, 1'b0, 1'b0);
        send(SEG_O, 3'd4, 1'b1, 1'b1);
        // Invalid symbol in DONE keeps msg_ok
        send(7'h12, 3'd7, 1'b0, 1'b1);
        chk("bad_in_done_state", 32'(dut.state_q), 32'(IDLE));
        idle(1);
        // Invalid codes from reset, then saturation of both counters
        do_reset();
        send(7'h12, 3'd7, 1'b0, 1'b0);
        chk("bad_state", 32'(dut.state_q), 32'(IDLE));
        chk("bad_err_cnt", 32'(bus.err_cnt), 32'd1);
        for (int i = 0; i < 20; i++) send(7'(7'h10 + i), 3'd7, 1'b0, 1'b0);
        idle(1);
        chk("sat_err_cnt", 32'(bus.err_cnt), 32'd15);
        chk("sat_char_cnt", 32'(bus.char_cnt), 32'd15);
        idle(2);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
